aes_req_arbiter: RTL and testbench

AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

---
 rtl/aes_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_aes_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - two-requester arbiter sharing one AES-128 core
//
// Purpose:
//   Accepts encryption requests from two requesters, runs them one at a time
//   on a shared AES core and returns each ciphertext to the requester that
//   issued it. Sequence: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Parameters:
//   ID_W            width of the request/response tag
//   TIMEOUT_CYCLES  WAIT cycles before a watchdog abort (1..255)
//
// Ports:
//   clk, rst                          clock; synchronous active-low reset
//   reqN_valid/ready                  request handshake, N = 0,1
//   reqN_plaintext/key/id             request operands and tag
//   rspN_valid/ready                  response handshake
//   rspN_data/id/err                  ciphertext, echoed tag, abort flag
//   core_start                        one-cycle start pulse to the core
//   core_plaintext/key                latched operands to the core
//   core_ciphertext, core_done        core result and completion pulse
//   busy                              high whenever not IDLE
//
// Optional feature:
//   AES_ARB_TIMEOUT_EN  builds the WAIT watchdog; otherwise rspN_err is 0
//   and WAIT lasts until core_done.

module aes_req_arbiter #(
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [127:0]    req0_plaintext,
    input  logic [127:0]    req0_key,
    input  logic [ID_W-1:0] req0_id,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [127:0]    req1_plaintext,
    input  logic [127:0]    req1_key,
    input  logic [ID_W-1:0] req1_id,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [127:0]    rsp0_data,
    output logic [ID_W-1:0] rsp0_id,
    output logic            rsp0_err,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [127:0]    rsp1_data,
    output logic [ID_W-1:0] rsp1_id,
    output logic            rsp1_err,

    output logic            core_start,
    output logic [127:0]    core_plaintext,
    output logic [127:0]    core_key,
    input  logic [127:0]    core_ciphertext,
    input  logic            core_done,

    output logic            busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("aes_req_arbiter: TIMEOUT_CYCLES must be 1..255");
    end

    logic [1:0]      state;
    logic            last_grant;
    logic            grant;
    logic [127:0]    op_pt;
    logic [127:0]    op_key;
    logic [ID_W-1:0] op_id;
    logic [127:0]    res_data;
    logic            res_err;

    logic            any_req;
    logic            pick1;
    logic            accept;
    logic            rsp_take;

    // On a tie, requester 1 wins only if requester 0 was served last.
    always_comb begin
        any_req  = req0_valid | req1_valid;
        pick1    = req1_valid & (~req0_valid | ~last_grant);
        // Ready is gated by rst so it reads 0 while reset is asserted.
        accept   = rst & (state == ST_IDLE) & any_req;
        rsp_take = grant ? rsp1_ready : rsp0_ready;
    end

    assign req0_ready     = accept & ~pick1;
    assign req1_ready     = accept & pick1;

    assign core_start     = (state == ST_ISSUE);
    assign core_plaintext = op_pt;
    assign core_key       = op_key;
    assign busy           = (state != ST_IDLE);

    assign rsp0_valid     = (state == ST_RESP) & ~grant;
    assign rsp1_valid     = (state == ST_RESP) & grant;
    assign rsp0_data      = res_data;
    assign rsp1_data      = res_data;
    assign rsp0_id        = op_id;
    assign rsp1_id        = op_id;
    assign rsp0_err       = res_err;
    assign rsp1_err       = res_err;

`ifdef AES_ARB_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;

    // wait_cnt holds the number of WAIT cycles already completed; the
    // abort fires on the cycle the count would reach TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= 8'd0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            op_pt      <= 128'd0;
            op_key     <= 128'd0;
            op_id      <= '0;
            res_data   <= 128'd0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant  <= pick1;
                        op_pt  <= pick1 ? req1_plaintext : req0_plaintext;
                        op_key <= pick1 ? req1_key       : req0_key;
                        op_id  <= pick1 ? req1_id        : req0_id;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving together with the timeout still wins.
                    if (core_done) begin
                        res_data <= core_ciphertext;
                        res_err  <= 1'b0;
                        state    <= ST_RESP;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        res_data <= 128'd0;
                        res_err  <= 1'b1;
                        state    <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_take) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb/tb_aes_req_arbiter.sv - directed self-checking bench for aes_req_arbiter

module tb_aes_req_arbiter;

    localparam int ID_W = 4;

    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req0_ready;
    logic [127:0]    req0_plaintext, req0_key;
    logic [ID_W-1:0] req0_id;
    logic            req1_valid, req1_ready;
    logic [127:0]    req1_plaintext, req1_key;
    logic [ID_W-1:0] req1_id;
    logic            rsp0_valid, rsp0_ready, rsp0_err;
    logic [127:0]    rsp0_data;
    logic [ID_W-1:0] rsp0_id;
    logic            rsp1_valid, rsp1_ready, rsp1_err;
    logic [127:0]    rsp1_data;
    logic [ID_W-1:0] rsp1_id;
    logic            core_start, core_done, busy;
    logic [127:0]    core_plaintext, core_key, core_ciphertext;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_req_arbiter #(.ID_W(ID_W), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_plaintext(req0_plaintext), .req0_key(req0_key), .req0_id(req0_id),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_plaintext(req1_plaintext), .req1_key(req1_key), .req1_id(req1_id),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_id(rsp0_id), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_id(rsp1_id), .rsp1_err(rsp1_err),
        .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
        .core_ciphertext(core_ciphertext), .core_done(core_done),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one full operation starting in an IDLE cycle with requests already
    // driven; g is the requester that must win, ct the core's answer.
    task automatic serve(input string tag, input bit g, input logic [127:0] pt,
                         input logic [127:0] key, input logic [ID_W-1:0] id,
                         input logic [127:0] ct);
        #1;
        chk({tag, ".req0_ready"}, req0_ready, !g);
        chk({tag, ".req1_ready"}, req1_ready, g);
        tick();
        chk({tag, ".core_start"}, core_start, 1'b1);
        chk({tag, ".core_pt"}, core_plaintext, pt);
        chk({tag, ".core_key"}, core_key, key);
        chk({tag, ".ready_issue"}, {req0_ready, req1_ready}, 2'b00);
        tick();
        chk({tag, ".start_wait"}, core_start, 1'b0);
        core_done = 1'b1;
        core_ciphertext = ct;
        tick();
        core_done = 1'b0;
        chk({tag, ".rsp_valid"}, {rsp1_valid, rsp0_valid}, g ? 2'b10 : 2'b01);
        chk({tag, ".rsp_data"}, g ? rsp1_data : rsp0_data, ct);
        chk({tag, ".rsp_id"}, g ? rsp1_id : rsp0_id, id);
        chk({tag, ".rsp_err"}, g ? rsp1_err : rsp0_err, 1'b0);
        if (g) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        #1;
        chk({tag, ".ready_resp"}, {req0_ready, req1_ready}, 2'b00);
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk({tag, ".busy_after"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_plaintext = '0; req0_key = '0; req0_id = '0;
        req1_valid = 1'b0; req1_plaintext = '0; req1_key = '0; req1_id = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        core_done = 1'b0; core_ciphertext = '0;

        // Reset state, with a request pending that must not be acknowledged.
        tick();
        req0_valid = 1'b1;
        tick();
        #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.req0_ready", req0_ready, 1'b0);
        chk("rst.rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("rst.core_start", core_start, 1'b0);
        chk("rst.core_pt", core_plaintext, 128'd0);
        chk("rst.core_key", core_key, 128'd0);
        chk("rst.rsp0_data", rsp0_data, 128'd0);
        chk("rst.rsp1_id", rsp1_id, 4'd0);
        chk("rst.err", {rsp1_err, rsp0_err}, 2'b00);
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Known-answer single request; latency accept T, start T+1, rsp T+3.
        req0_valid = 1'b1; req0_plaintext = KAT_PT; req0_key = KAT_KEY; req0_id = 4'd3;
        #1;
        chk("kat.req0_ready", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk("kat.start_T1", core_start, 1'b1);
        chk("kat.busy", busy, 1'b1);
        tick();
        core_done = 1'b1; core_ciphertext = KAT_CT;
        chk("kat.valid_T2", rsp0_valid, 1'b0);
        tick();
        core_done = 1'b0;
        chk("kat.valid_T3", rsp0_valid, 1'b1);
        chk("kat.data", rsp0_data, KAT_CT);
        chk("kat.id", rsp0_id, 4'd3);
        chk("kat.err", rsp0_err, 1'b0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("kat.idle", busy, 1'b0);

        // Alternating grants from reset with both requesters always valid.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req0_valid = 1'b1; req0_plaintext = 128'h0123456789abcdef0011223344556677;
        req0_key = 128'hffeeddccbbaa99887766554433221100; req0_id = 4'd5;
        req1_valid = 1'b1; req1_plaintext = 128'hdeadbeefcafef00d1234567890abcdef;
        req1_key = 128'h55aa55aa55aa55aa0f0f0f0ff0f0f0f0; req1_id = 4'd9;
        serve("alt0", 1'b0, req0_plaintext, req0_key, 4'd5, ~req0_plaintext);
        serve("alt1", 1'b1, req1_plaintext, req1_key, 4'd9, ~req1_plaintext);
        serve("alt2", 1'b0, req0_plaintext, req0_key, 4'd5, ~req0_plaintext);
        serve("alt3", 1'b1, req1_plaintext, req1_key, 4'd9, ~req1_plaintext);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure on requester 1 while requester 0 keeps asking.
        req1_valid = 1'b1; req1_id = 4'd7;
        tick();
        req1_valid = 1'b0;
        tick();
        core_done = 1'b1; core_ciphertext = 128'h11112222333344445555666677778888;
        tick();
        core_done = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("bp.valid%0d", i), rsp1_valid, 1'b1);
            chk($sformatf("bp.data%0d", i), rsp1_data, 128'h11112222333344445555666677778888);
            chk($sformatf("bp.req0_ready%0d", i), req0_ready, 1'b0);
            chk($sformatf("bp.busy%0d", i), busy, 1'b1);
            tick();
        end
        chk("bp.id", rsp1_id, 4'd7);
        req0_valid = 1'b0;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        chk("bp.idle", busy, 1'b0);

        // Reset during WAIT, then a late core_done.
        req0_valid = 1'b1; req0_plaintext = 128'haaaa; req0_key = 128'hbbbb; req0_id = 4'd2;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("rw.in_wait", busy, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        core_done = 1'b1; core_ciphertext = 128'hcccc;
        #1;
        chk("rw.busy0", busy, 1'b0);
        chk("rw.core_pt", core_plaintext, 128'd0);
        tick();
        core_done = 1'b0;
        chk("rw.busy1", busy, 1'b0);
        chk("rw.rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("rw.rsp_data", rsp0_data, 128'd0);
        chk("rw.core_start", core_start, 1'b0);
        chk("rw.core_key", core_key, 128'd0);

        // Spurious core_done in IDLE and in RESP.
        core_done = 1'b1; core_ciphertext = 128'h9999;
        tick();
        core_done = 1'b0;
        chk("sp.idle_busy", busy, 1'b0);
        chk("sp.idle_data", rsp0_data, 128'd0);
        req0_valid = 1'b1; req0_plaintext = 128'h1234; req0_key = 128'h5678; req0_id = 4'd11;
        tick();
        req0_valid = 1'b0;
        tick();
        core_done = 1'b1; core_ciphertext = 128'h4321;
        tick();
        core_ciphertext = 128'h7777;
        tick();
        core_done = 1'b0;
        chk("sp.resp_valid", rsp0_valid, 1'b1);
        chk("sp.resp_data", rsp0_data, 128'h4321);
        chk("sp.resp_id", rsp0_id, 4'd11);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("sp.resp_done", busy, 1'b0);

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYCLES=4: four WAIT cycles, then abort.
        req0_valid = 1'b1; req0_id = 4'd6;
        tick();
        req0_valid = 1'b0;
        chk("to.start", core_start, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to.wait%0d", i), rsp0_valid, 1'b0);
        end
        tick();
        chk("to.valid", rsp0_valid, 1'b1);
        chk("to.err", rsp0_err, 1'b1);
        chk("to.data", rsp0_data, 128'd0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // core_done on the fourth WAIT cycle beats the abort.
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick(); tick(); tick(); tick();
        core_done = 1'b1; core_ciphertext = 128'hface;
        chk("tod.wait", rsp0_valid, 1'b0);
        tick();
        core_done = 1'b0;
        chk("tod.valid", rsp0_valid, 1'b1);
        chk("tod.err", rsp0_err, 1'b0);
        chk("tod.data", rsp0_data, 128'hface);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
